pipe_stage_skid_reg: RTL
========================

Name: pipe_stage_skid_reg

Overview:
Generic, parametrised successor to the fixed-field inter-stage pipeline registers (DE, EM, MW).
- Carries a control bundle, NS scalar lanes and NV vector lanes through one pipeline boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream backpressure (in_ready) is fully registered.
- Adds flush, bubble propagation and saturating stall/flush performance counters. The old blocks have none of these.

Parameters:
CW, 16, control bundle width (write enables, ALU ctrl, flags, etc.)
N, 24, scalar lane width
NS, 3, number of scalar lanes
VW, 256, vector lane width
NV, 2, number of vector lanes
CNTW, 16, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
clr  in  1  synchronous flush; empties the stage
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat (registered)
ctrl_in  in  CW  control bundle
sdata_in  in  NS*N  scalar lanes, lane i at [i*N +: N]
vdata_in  in  NV*VW  vector lanes, lane j at [j*VW +: VW]
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
ctrl_out  out  CW  registered control bundle
sdata_out  out  NS*N  registered scalar lanes
vdata_out  out  NV*VW  registered vector lanes
stall_cnt  out  CNTW  cycles with out_valid=1 and out_ready=0, saturating
flush_cnt  out  CNTW  cycles with clr=1 while rst=0, saturating

Behaviour:
- Storage: main register (out_valid, ctrl/sdata/vdata_out) plus skid register (skid_valid, same fields).
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.
- in_ready = ~skid_valid. It is a pure register output with no combinational path from out_ready.
- Reset (rst=1): out_valid=0, skid_valid=0, in_ready=1, ctrl_out/sdata_out/vdata_out=0, skid data=0, stall_cnt=0, flush_cnt=0.
- Flush (clr=1, rst=0): same as reset for valids, data and in_ready. Zeroing ctrl_out kills all write enables downstream.
  - stall_cnt holds.
  - flush_cnt increments, saturating at 2^CNTW-1.
  - A beat presented with in_fire in the same cycle is discarded. Upstream is flushed by the same hazard unit.
- Priority: rst > clr > normal operation.
- Normal update, per cycle, when main is empty (out_valid=0) or out_fire:
  - If skid_valid: main <= skid, out_valid=1, skid_valid<=0.
  - Else if in_fire: main <= inputs, out_valid=1.
  - Else: out_valid<=0 (bubble). Main data holds its last value.
- Normal update when out_valid=1 and out_ready=0 (stalled):
  - Main holds.
  - If in_fire, skid <= inputs and skid_valid<=1.
- skid_valid=1 implies in_ready=0, so skid can never be overwritten. The case of main loading from skid in the same cycle as in_fire cannot occur.
- Latency: 1 cycle from in_fire to out_valid when not stalled. Throughput: 1 beat/cycle sustained.
- Ordering: beats leave in acceptance order, none lost or duplicated except those removed by flush.
- Full condition: main and skid both valid, in_ready=0. Recovery takes 2 out_fire cycles to empty.
- stall_cnt increments every cycle with out_valid & ~out_ready (rst=0, clr=0) and saturates, with no wrap.
- All lanes are treated identically. Data is never modified, only stored.
- Total state is 2*(CW+NS*N+NV*VW)+2 flops plus the counters.

Test Plan:
1. Streaming: rst 2 cycles, then in_valid=1 and out_ready=1 for 8 cycles with ctrl_in=k, sdata lane0=k (k=1..8) -> out_valid rises 1 cycle after the first beat, ctrl_out=1..8 in consecutive cycles, in_ready stays 1, stall_cnt=0.
2. Backpressure/skid: stream beats 0xA,0xB,0xC, drop out_ready after 0xA is in main -> 0xB captured in skid, in_ready=0 the next cycle, 0xC held upstream. Raise out_ready -> outputs 0xA,0xB,0xC in order, no loss. stall_cnt equals the number of stalled cycles.
3. Flush mid-operation: main and skid both full with 0x11,0x22, assert clr for 1 cycle with in_valid=1 (0x33) -> next cycle out_valid=0, ctrl_out=0, in_ready=1, 0x33 never appears, flush_cnt=1, stall_cnt unchanged.
4. Reset mid-stall: stalled with skid full, assert rst -> all outputs 0, in_ready=1, both counters 0. First beat after release has latency 1.
5. Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 -> out_valid pattern 0,1,0,1,0, delayed by one cycle. Data is held (not zeroed) during bubble cycles.
6. Counter saturation: CNTW=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15 and never wraps to 0.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_reg
// Purpose  : Parametrised pipeline boundary register with a 2-entry skid
//            buffer, flush, and saturating stall/flush counters.
// Revision : 1.0
// ============================================================================
module pipe_stage_skid_reg #(
    parameter int CW   = 16,
    parameter int N    = 24,
    parameter int NS   = 3,
    parameter int VW   = 256,
    parameter int NV   = 2,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CW-1:0]      ctrl_in,
    input  logic [NS*N-1:0]    sdata_in,
    input  logic [NV*VW-1:0]   vdata_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      ctrl_out,
    output logic [NS*N-1:0]    sdata_out,
    output logic [NV*VW-1:0]   vdata_out,
    output logic [CNTW-1:0]    stall_cnt,
    output logic [CNTW-1:0]    flush_cnt
);

    localparam int              c_sw      = NS * N;
    localparam int              c_vw      = NV * VW;
    localparam logic [CNTW-1:0] c_cnt_max = '1;
    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

    logic              r_out_valid;
    logic [CW-1:0]     r_ctrl;
    logic [c_sw-1:0]   r_sdata;
    logic [c_vw-1:0]   r_vdata;

    logic              r_skid_valid;
    logic [CW-1:0]     r_skid_ctrl;
    logic [c_sw-1:0]   r_skid_sdata;
    logic [c_vw-1:0]   r_skid_vdata;

    logic [CNTW-1:0]   r_stall_cnt;
    logic [CNTW-1:0]   r_flush_cnt;

    logic              w_in_fire;
    logic              w_main_free;
    logic              w_stalled;

    // in_ready is derived only from the skid flop, never from out_ready.
    assign w_in_fire   = in_valid & ~r_skid_valid;
    assign w_main_free = ~r_out_valid | out_ready;
    assign w_stalled   = r_out_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            r_out_valid  <= r_skid_valid | w_in_fire;
            r_skid_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Main data holds through bubbles; only a new beat or a flush changes it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ctrl  <= '0;
            r_sdata <= '0;
            r_vdata <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_ctrl  <= r_skid_ctrl;
                r_sdata <= r_skid_sdata;
                r_vdata <= r_skid_vdata;
            end else if (w_in_fire) begin
                r_ctrl  <= ctrl_in;
                r_sdata <= sdata_in;
                r_vdata <= vdata_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_skid_ctrl  <= '0;
            r_skid_sdata <= '0;
            r_skid_vdata <= '0;
        end else if (!w_main_free && w_in_fire) begin
            r_skid_ctrl  <= ctrl_in;
            r_skid_sdata <= sdata_in;
            r_skid_vdata <= vdata_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr) begin
            if (r_flush_cnt != c_cnt_max) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end else if (w_stalled && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_out_valid;
    assign ctrl_out  = r_ctrl;
    assign sdata_out = r_sdata;
    assign vdata_out = r_vdata;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
